// File: rtl/aes_pkg.sv
// Shared AES constants and types: forward S-box table,
// block type and byte count used across the round datapath.
package aes_pkg;

  localparam int aes_bytes_lp = 16;

  typedef logic [0:127] aes_block_t;

  localparam logic [7:0] sbox_table [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Handshake bundle for sub_bytes_iter: valid/ready in,
// valid/yumi out.
interface sub_bytes_iter_if;
  import aes_pkg::*;

  aes_block_t block_i;
  logic       v_i;
  logic       ready_o;
  aes_block_t block_o;
  logic       v_o;
  logic       yumi_i;

  modport slave (
    input  block_i, v_i, yumi_i,
    output ready_o, block_o, v_o
  );

  modport master (
    output block_i, v_i, yumi_i,
    input  ready_o, block_o, v_o
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup.
// Shared by SubBytes and key expansion.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = sbox_table[din];
endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: lanes_p bytes per cycle through
// shared S-boxes, in-place on a registered state.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int lanes_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  sub_bytes_iter_if.slave bus
);
  localparam int cycles_lp = aes_bytes_lp / lanes_p;
  localparam int cnt_w_lp =
    (cycles_lp > 1) ? $clog2(cycles_lp) : 1;

  if (!(lanes_p == 1 || lanes_p == 2 ||
        lanes_p == 4 || lanes_p == 8 ||
        lanes_p == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: illegal lanes_p");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e state_r, state_n;
  logic [cnt_w_lp-1:0] cnt_r;
  aes_block_t data_r;

  logic load, step, last;
  logic [6:0] base;
  logic [7:0] sub [lanes_p];

  assign last = (cnt_r == cnt_w_lp'(cycles_lp - 1));
  // bit offset of the lane group selected this cycle
  assign base = 7'(32'(cnt_r) * lanes_p * 8);

  for (genvar i = 0; i < lanes_p; i++) begin : g_lane
    aes_sbox u_sbox (
      .din  (data_r[base + 7'(i*8) +: 8]),
      .dout (sub[i])
    );
  end

  always_comb begin
    state_n = state_r;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (bus.v_i) begin
          load    = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        if (bus.yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      data_r  <= '0;
    end else begin
      state_r <= state_n;
      if (load) begin
        data_r <= bus.block_i;
        cnt_r  <= '0;
      end else if (step) begin
        for (int i = 0; i < lanes_p; i++)
          data_r[base + 7'(i*8) +: 8] <= sub[i];
        cnt_r <= last ? '0 : cnt_r + 1'b1;
      end
    end
  end

  assign bus.block_o = data_r;
  assign bus.ready_o = (state_r == IDLE);
  assign bus.v_o     = (state_r == DONE);
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench: lanes_p = 1, 4, 16 instances checked
// against a GF(2^8) inverse + affine S-box model.
module tb_sub_bytes_iter;
  import aes_pkg::*;

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int lanes_a [3] = '{1, 4, 16};
  aes_block_t bi [3];
  logic vi [3];
  logic yu [3];
  aes_block_t bo [3];
  logic vo [3];
  logic rdy [3];

  sub_bytes_iter_if if0 ();
  sub_bytes_iter_if if1 ();
  sub_bytes_iter_if if2 ();

  sub_bytes_iter #(.lanes_p(1)) u0 (
    .clk_i(clk), .reset_i(rst), .bus(if0.slave));
  sub_bytes_iter #(.lanes_p(4)) u1 (
    .clk_i(clk), .reset_i(rst), .bus(if1.slave));
  sub_bytes_iter #(.lanes_p(16)) u2 (
    .clk_i(clk), .reset_i(rst), .bus(if2.slave));

  assign if0.block_i = bi[0];
  assign if0.v_i     = vi[0];
  assign if0.yumi_i  = yu[0];
  assign if1.block_i = bi[1];
  assign if1.v_i     = vi[1];
  assign if1.yumi_i  = yu[1];
  assign if2.block_i = bi[2];
  assign if2.v_i     = vi[2];
  assign if2.yumi_i  = yu[2];
  assign bo[0]  = if0.block_o;
  assign vo[0]  = if0.v_o;
  assign rdy[0] = if0.ready_o;
  assign bo[1]  = if1.block_o;
  assign vo[1]  = if1.v_o;
  assign rdy[1] = if1.ready_o;
  assign bo[2]  = if2.block_o;
  assign vo[2]  = if2.v_o;
  assign rdy[2] = if2.ready_o;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++)
        assert (!(yu[i] && !vo[i]))
          else $error("yumi_i without v_o on dut %0d", i);
    end
  end

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] r, s;
    for (int b = 1; b < 256; b++)
      if (x != 8'h00 && gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
    r = inv;
    s = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic aes_block_t sub_m(input aes_block_t x);
    aes_block_t y;
    for (int k = 0; k < 16; k++)
      y[8*k +: 8] = sbox_m(x[8*k +: 8]);
    return y;
  endfunction

  function automatic aes_block_t rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic accept(input int d, input aes_block_t b);
    @(negedge clk);
    bi[d] = b;
    vi[d] = 1'b1;
    @(negedge clk);
    vi[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output int lat);
    logic busy_rdy = 1'b0;
    lat = 0;
    while (!vo[d] && lat < 40) begin
      if (rdy[d]) busy_rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (rdy[d]) busy_rdy = 1'b1;
    tests++;
    if (busy_rdy !== 1'b0) begin
      fails++;
      $display("FAIL ready_busy d%0d ready_o seen=%b need 0",
               d, busy_rdy);
    end
  endtask

  task automatic release_out(input int d);
    yu[d] = 1'b1;
    @(negedge clk);
    yu[d] = 1'b0;
    tests++;
    if (rdy[d] !== 1'b1 || vo[d] !== 1'b0) begin
      fails++;
      $display("FAIL release d%0d ready=%b v=%b need 1/0",
               d, rdy[d], vo[d]);
    end
  endtask

  task automatic run_check(input int d, input aes_block_t b,
                           input aes_block_t exp, input string nm);
    int lat;
    int cl = 16 / lanes_a[d];
    accept(d, b);
    wait_done(d, lat);
    tests++;
    if (lat !== cl) begin
      fails++;
      $display("FAIL %s_lat d%0d got %0d need %0d", nm, d, lat, cl);
    end
    tests++;
    if (bo[d] !== exp) begin
      fails++;
      $display("FAIL %s_data d%0d got %h need %h",
               nm, d, bo[d], exp);
    end
    release_out(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (rdy[d] !== 1'b1 || vo[d] !== 1'b0 ||
          bo[d] !== '0) begin
        fails++;
        $display("FAIL reset d%0d ready=%b v=%b blk=%h need 1/0/0",
                 d, rdy[d], vo[d], bo[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fips();
    aes_block_t i_b = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    aes_block_t o_b = 128'hd42711aee0bf98f1b8b45de51e415230;
    run_check(1, i_b, o_b, "fips");
  endtask

  task automatic test_zero();
    aes_block_t z = '0;
    aes_block_t e = {16{8'h63}};
    run_check(0, z, e, "zero1");
    run_check(2, z, e, "zero16");
  endtask

  task automatic test_random();
    for (int d = 0; d < 3; d++) begin
      aes_block_t b = rnd_blk();
      run_check(d, b, sub_m(b), "rand");
    end
  endtask

  task automatic test_byte_order();
    aes_block_t b = '0;
    aes_block_t e = {16{8'h63}};
    b[0 +: 8]   = 8'h53;
    b[120 +: 8] = 8'hff;
    e[0 +: 8]   = 8'hed;
    e[120 +: 8] = 8'h16;
    run_check(1, b, e, "order");
  endtask

  task automatic test_backpressure();
    aes_block_t b = rnd_blk();
    aes_block_t e = sub_m(b);
    logic bad = 1'b0;
    int lat;
    accept(1, b);
    wait_done(1, lat);
    for (int c = 0; c < 10; c++) begin
      if (vo[1] !== 1'b1 || rdy[1] !== 1'b0 || bo[1] !== e)
        bad = 1'b1;
      vi[1] = (c == 3);
      bi[1] = ~b;
      @(negedge clk);
    end
    vi[1] = 1'b0;
    tests++;
    if (bad !== 1'b0 || bo[1] !== e) begin
      fails++;
      $display("FAIL backpressure got %h bad=%b need %h",
               bo[1], bad, e);
    end
    release_out(1);
  endtask

  task automatic test_back_to_back(input int d);
    aes_block_t q [$];
    int acc [$];
    int cl = 16 / lanes_a[d];
    int cyc = 0;
    int got = 0;
    int sent = 0;
    logic took;
    aes_block_t exp;
    @(negedge clk);
    bi[d] = rnd_blk();
    vi[d] = 1'b1;
    while (got < 3 && cyc < 200) begin
      yu[d] = vo[d];
      if (vo[d]) begin
        exp = (q.size() > 0) ? q.pop_front() : '0;
        tests++;
        if (bo[d] !== exp) begin
          fails++;
          $display("FAIL b2b_data d%0d got %h need %h",
                   d, bo[d], exp);
        end
        got++;
      end
      took = vi[d] && rdy[d];
      if (took) begin
        q.push_back(sub_m(bi[d]));
        acc.push_back(cyc);
        sent++;
      end
      @(negedge clk);
      cyc++;
      if (took) begin
        if (sent < 3) bi[d] = rnd_blk();
        else vi[d] = 1'b0;
      end
    end
    yu[d] = 1'b0;
    vi[d] = 1'b0;
    tests++;
    if (got !== 3 || acc.size() !== 3) begin
      fails++;
      $display("FAIL b2b_count d%0d got %0d acc %0d need 3",
               d, got, acc.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (acc[i+1] - acc[i] !== cl + 2) begin
          fails++;
          $display("FAIL b2b_space d%0d got %0d need %0d",
                   d, acc[i+1] - acc[i], cl + 2);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    aes_block_t b = rnd_blk();
    logic stale = 1'b0;
    accept(1, b);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (vo[1] !== 1'b0 || rdy[1] !== 1'b1 || bo[1] !== '0) begin
      fails++;
      $display("FAIL rst_busy v=%b ready=%b blk=%h need 0/1/0",
               vo[1], rdy[1], bo[1]);
    end
    for (int c = 0; c < 8; c++) begin
      if (vo[1] !== 1'b0) stale = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (stale !== 1'b0) begin
      fails++;
      $display("FAIL rst_stale v_o seen=%b need 0", stale);
    end
    b = rnd_blk();
    run_check(1, b, sub_m(b), "after_rst");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      bi[d] = '0;
      vi[d] = 1'b0;
      yu[d] = 1'b0;
    end
    test_reset();
    test_fips();
    test_zero();
    test_random();
    test_byte_order();
    test_backpressure();
    test_back_to_back(1);
    test_back_to_back(0);
    test_back_to_back(2);
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
Iterative AES SubBytes stage that sits directly upstream of shift_rows in the encryption round datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes lanes_p bytes per cycle through shared S-box instances. It presents the substituted state with a valid/yumi handshake. The output feeds shift_rows unchanged, using the same [0:127] big-endian, column-major byte order: byte k = bits [8k +: 8], and bytes 0..3 form column 0.

Parameters:
lanes_p, 4, number of S-box instances, which is also the number of bytes substituted per cycle; legal values 1, 2, 4, 8, 16 (elaboration error otherwise)

Ports:
clk_i  input  1  clock; all state updates on its rising edge
reset_i  input  1  synchronous, active-high reset
block_i  input  [0:127]  state to substitute; sampled only on accept (v_i & ready_o)
v_i  input  1  block_i valid
ready_o  output  1  block can accept a new state
block_o  output  [0:127]  substituted state; meaningful only while v_o=1
v_o  output  1  block_o valid
yumi_i  input  1  consumer takes block_o; legal only when v_o=1

Behaviour:
- Reset is synchronous and active-high on reset_i; one clock, clk_i.
- Derived constant: cycles_lp = 16/lanes_p. Counter width is max(1, log2(cycles_lp)).
- Registers: data_r [0:127], cnt_r, state_r.
- Reset values: state_r=IDLE, cnt_r=0, data_r=0. Resulting outputs: ready_o=1, v_o=0, block_o=0.
- block_o is always driven from data_r; there is no combinational path from block_i to block_o.
- ready_o = (state_r==IDLE). v_o = (state_r==DONE). Neither depends combinationally on v_i or yumi_i.
- FSM:
  - IDLE: on v_i=1, data_r<=block_i, cnt_r<=0, go to BUSY. Otherwise hold.
  - BUSY: bytes cnt_r*lanes_p .. cnt_r*lanes_p+lanes_p-1 of data_r are replaced in place by sbox(byte); all other bytes hold. If cnt_r==cycles_lp-1, go to DONE and set cnt_r<=0; otherwise cnt_r<=cnt_r+1.
  - DONE: hold data_r. On yumi_i=1, go to IDLE.
- Latency: a state accepted at edge t produces v_o=1 from edge t+cycles_lp (lanes_p=4 gives 4 cycles; lanes_p=16 gives 1 cycle).
- Throughput: one state per cycles_lp+2 cycles with an always-ready consumer (accept, BUSY cycles, DONE/yumi). Acceptance in DONE is not overlapped, by design.
- Backpressure: with yumi_i=0, DONE holds indefinitely and block_o stays stable.
- v_i while not ready_o is ignored. The upstream stage must hold v_i and block_i until ready_o.
- yumi_i while v_o=0 is a protocol violation; the design ignores it. The bench flags it with an assertion.
- reset_i mid-BUSY or mid-DONE: the in-flight state is discarded. The next cycle shows reset values and no v_o pulse.
- reset_i has priority over v_i and yumi_i in the same cycle.
- S-box: standard FIPS-197 forward table, purely combinational, byte in, byte out.
- Lane selection: indexed part-select on data_r. Out-of-range lanes are impossible by construction.

Decomposition:
- Shared package aes_pkg:
  - sbox_table constant, 256 x 8-bit forward S-box.
  - aes_block_t typedef, logic [0:127].
  - aes_bytes_lp = 16.
- Sub-module aes_sbox: 8-bit in, 8-bit out, combinational lookup into aes_pkg::sbox_table. It is instantiated lanes_p times and reused later by the key-expansion block.
- FSM states: local enum {IDLE, BUSY, DONE} inside sub_bytes_iter.

Test Plan:
- FIPS-197 App. B round 1, lanes_p=4: block_i=193de3bea0f4e22b9ac68d2ae9f84808, v_i=1 for one cycle -> v_o rises 4 cycles after accept, block_o=d42711aee0bf98f1b8b45de51e415230.
- All-zero state, lanes_p=1 and lanes_p=16: block_i=0 -> block_o=16 bytes of 63. v_o arrives after 16 and 1 cycles respectively, and ready_o=0 throughout BUSY/DONE.
- Backpressure: hold yumi_i=0 for 10 cycles after v_o -> v_o and block_o stay stable, ready_o=0, and a v_i pulse during this time is not captured. Then yumi_i=1 -> IDLE next cycle, ready_o=1.
- Back-to-back with yumi_i tied high, 3 random states vs a software model -> all outputs match. Accepts are spaced exactly cycles_lp+2 cycles apart.
- Reset mid-BUSY: reset_i=1 at cnt_r=2 -> next cycle v_o=0, ready_o=1, block_o=0. No stale v_o ever appears, and a fresh state afterwards yields the correct result.
- Byte-order check: block_i with only byte 0=53 and byte 15=ff, all others 00 -> block_o byte 0=ed, byte 15=16, all other bytes 63.
